// File: rtl/bcd_pkg.sv
// Shared types and constants for the serial double-dabble converter slice.
package bcd_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_t;

   localparam int unsigned BCD_DIGIT_W = 4;
   localparam int unsigned ADD3_THRESH = 5;
   localparam int unsigned ADD3_VAL    = 3;

   // Ceiling log2; returns at least 1 so it can size a select or counter.
   function automatic int unsigned clog2(input int unsigned v);
      int unsigned r;
      r = 1;
      while ((32'd1 << r) < v) r = r + 1;
      return r;
   endfunction

endpackage

// File: rtl/bcd_conv_arbiter_if.sv
// Request/response bundle between the requesters, the consumer and the converter.
interface bcd_conv_arbiter_if
   import bcd_pkg::*;
#(
   parameter int unsigned BIN_W  = 8,
   parameter int unsigned DIGITS = 3,
   parameter int unsigned NREQ   = 2,
   parameter int unsigned ID_W   = 1
);
   logic [NREQ-1:0]               req_valid;
   logic [NREQ*BIN_W-1:0]         req_data;
   logic [NREQ-1:0]               req_ready;
   logic                          rsp_valid;
   logic [BCD_DIGIT_W*DIGITS-1:0] rsp_bcd;
   logic [ID_W-1:0]               rsp_id;
   logic                          rsp_ready;

   modport master (
      output req_valid, req_data, rsp_ready,
      input  req_ready, rsp_valid, rsp_bcd, rsp_id
   );

   modport slave (
      input  req_valid, req_data, rsp_ready,
      output req_ready, rsp_valid, rsp_bcd, rsp_id
   );
endinterface

// File: rtl/bcd_add3_digit.sv
// One BCD digit of double-dabble correction: add 3 when the digit is 5 or more.
module bcd_add3_digit
   import bcd_pkg::*;
(
   input  logic [BCD_DIGIT_W-1:0] i_digit,
   output logic [BCD_DIGIT_W-1:0] o_digit
);
   always_comb begin
      o_digit = i_digit;
      if (i_digit >= BCD_DIGIT_W'(ADD3_THRESH))
         o_digit = i_digit + BCD_DIGIT_W'(ADD3_VAL);
   end
endmodule

// File: rtl/bcd_conv_arbiter.sv
// Round-robin shared serial binary-to-BCD converter, one operand bit per clock.
module bcd_conv_arbiter
   import bcd_pkg::*;
#(
   parameter int unsigned BIN_W  = 8,
   parameter int unsigned DIGITS = 3,
   parameter int unsigned NREQ   = 2,
   parameter int unsigned ID_W   = 1
)(
   input  logic                    clk,
   input  logic                    reset,
   bcd_conv_arbiter_if.slave       bus,
   output logic                    busy
);
   localparam int unsigned ACC_W = BCD_DIGIT_W * DIGITS;
   localparam int unsigned IDX_W = clog2(NREQ);
   localparam int unsigned CNT_W = clog2(BIN_W);

   if (ID_W < clog2(NREQ)) begin : g_bad_id_w
      $error("bcd_conv_arbiter: ID_W too narrow for NREQ");
   end

   state_t             r_state;
   state_t             w_state_nxt;
   logic [BIN_W-1:0]   r_bin;
   logic [ACC_W-1:0]   r_acc;
   logic [ACC_W-1:0]   r_bcd;
   logic [CNT_W-1:0]   r_cnt;
   logic [ID_W-1:0]    r_id;
   logic [IDX_W-1:0]   r_last;

   logic [BIN_W-1:0]   w_req_op [NREQ];
   logic               w_gnt_vld;
   logic [IDX_W-1:0]   w_gnt_idx;
   logic [NREQ-1:0]    w_req_ready;
   logic [ACC_W-1:0]   w_acc_adj;
   logic [ACC_W-1:0]   w_acc_shift;
   logic               w_last_bit;

   for (genvar k = 0; k < NREQ; k++) begin : g_op
      assign w_req_op[k] = bus.req_data[k*BIN_W +: BIN_W];
   end

   // Search starts just past the previous winner so every requester gets a turn.
   always_comb begin
      int unsigned sum;
      w_gnt_vld = 1'b0;
      w_gnt_idx = '0;
      sum       = 0;
      for (int unsigned i = 1; i <= NREQ; i++) begin
         sum = 32'(r_last) + i;
         if (sum >= NREQ) sum = sum - NREQ;
         if (!w_gnt_vld && bus.req_valid[IDX_W'(sum)]) begin
            w_gnt_vld = 1'b1;
            w_gnt_idx = IDX_W'(sum);
         end
      end
   end

   for (genvar d = 0; d < DIGITS; d++) begin : g_add3
      bcd_add3_digit u_add3 (
         .i_digit (r_acc[d*BCD_DIGIT_W +: BCD_DIGIT_W]),
         .o_digit (w_acc_adj[d*BCD_DIGIT_W +: BCD_DIGIT_W])
      );
   end

   assign w_acc_shift = {w_acc_adj[ACC_W-2:0], r_bin[BIN_W-1]};
   assign w_last_bit  = (r_cnt == CNT_W'(BIN_W - 1));

   always_ff @(posedge clk) begin
      if (reset) r_state <= IDLE;
      else       r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      w_req_ready = '0;
      case (r_state)
         IDLE: begin
            if (w_gnt_vld) begin
               w_req_ready[w_gnt_idx] = 1'b1;
               w_state_nxt            = SHIFT;
            end
         end
         SHIFT: begin
            if (w_last_bit) w_state_nxt = DONE;
         end
         DONE: begin
            if (bus.rsp_ready) w_state_nxt = IDLE;
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   // Accumulator and published result are separate so rsp_bcd never shows partial sums.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_bin  <= '0;
         r_acc  <= '0;
         r_bcd  <= '0;
         r_cnt  <= '0;
         r_id   <= '0;
         r_last <= IDX_W'(NREQ - 1);
      end else begin
         case (r_state)
            IDLE: begin
               if (w_gnt_vld) begin
                  r_bin  <= w_req_op[w_gnt_idx];
                  r_acc  <= '0;
                  r_cnt  <= '0;
                  r_id   <= ID_W'(w_gnt_idx);
                  r_last <= w_gnt_idx;
               end
            end
            SHIFT: begin
               r_acc <= w_acc_shift;
               r_bin <= {r_bin[BIN_W-2:0], 1'b0};
               r_cnt <= r_cnt + CNT_W'(1);
               if (w_last_bit) r_bcd <= w_acc_shift;
            end
            default: ;
         endcase
      end
   end

   assign bus.req_ready = w_req_ready;
   assign bus.rsp_valid = (r_state == DONE);
   assign bus.rsp_bcd   = r_bcd;
   assign bus.rsp_id    = r_id;
   assign busy          = (r_state != IDLE);

endmodule
